risc_pipeline_ctrl: RTL and testbench
=====================================

// Module: risc_pipeline_ctrl
// PURPOSE
//  Pipeline sequencer for the 4-stage RISC core (IF, DOF, EX, WB). Takes decoder control fields for the
//  instruction in DOF and shadows them down EX/WB. Drives PC/IR enables, pc_sel, EX bubble insertion and
//  IR flush. Resolves data hazards by stalling, branches by flushing; counts stall and flush cycles.
// PARAMETERS
//  RF_WRITE_THROUGH  1   1: reg file forwards same-cycle WB write to reads; 0: WB dest also stalls DOF
//  CNT_W             16  width of perf counters (saturating)
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  mem_wait     in   1   memory not ready; freeze whole pipeline
//  rw_dof       in   1   decoder RW, DOF instruction
//  da_dof       in   5   decoder DA
//  aa_dof       in   5   decoder AA
//  ba_dof       in   5   decoder BA
//  ma_dof       in   1   decoder MA (1 = A operand not from reg file)
//  mb_dof       in   1   decoder MB (1 = B operand is immediate)
//  bs_dof       in   2   decoder BS
//  ps_dof       in   1   decoder PS
//  zero_ex      in   1   ALU Z flag of instruction now in EX
//  pc_en        out  1   PC register load enable
//  pc_sel       out  2   00 PC+1, 01 branch target, 10 reg jump (JMR), 11 jump/JML target
//  ir_en        out  1   IF/DOF (IR) register load enable
//  ir_flush     out  1   load NOP into IR this edge
//  ex_bubble    out  1   load NOP controls into DOF/EX register this edge
//  stall_cnt    out  CNT_W  cycles lost to data hazards
//  flush_cnt    out  CNT_W  taken branches/jumps
// BEHAVIOUR
//  - Shadow regs: {rw,da,bs,ps}_ex and {rw,da}_wb. Each edge when !mem_wait: wb <= ex; ex <= ex_bubble ? 0
//    : dof fields. While mem_wait=1 all shadows and counters hold.
//  - Reset (rst_n=0, async): shadows and counters 0. Outputs: pc_en=0, ir_en=0, ir_flush=1, ex_bubble=1,
//    pc_sel=00. First edge after release fetches from reset PC.
//  - taken = (bs_ex==01 & (zero_ex ^ ps_ex)) | bs_ex==10 | bs_ex==11 (BZ PS=0, BNZ PS=1, JMR, JMP/JML).
//  - Source use: A used iff ma_dof=0; B used iff mb_dof=0. R0 never hazards (da==0 ignored).
//  - hazard = used src == da_ex & rw_ex | (RF_WRITE_THROUGH==0 & used src == da_wb & rw_wb).
//  - Outputs are combinational from shadows + inputs; priority mem_wait > taken > hazard > normal:
//    mem_wait: pc_en=0 ir_en=0 ir_flush=0 ex_bubble=0 pc_sel=00 (pure freeze).
//    taken:    pc_en=1 pc_sel=bs_ex ir_en=1 ir_flush=1 ex_bubble=1 (kill IF and DOF; 2-cycle penalty,
//              no delay slot); flush_cnt+1.
//    hazard:   pc_en=0 ir_en=0 ir_flush=0 ex_bubble=1 pc_sel=00; stall_cnt+1. Repeats until the
//              producer leaves EX (and WB if RF_WRITE_THROUGH=0): max 1 (resp. 2) stall cycles.
//    normal:   pc_en=1 ir_en=1 ir_flush=0 ex_bubble=0 pc_sel=00.
//  - Taken branch with a simultaneous DOF hazard: branch wins; no stall counted.
//  - Branch/JMP in DOF never stalls on itself; target is resolved only in EX.
//  - JML (RW=1, BS=11) flushes and its link write shadows to WB normally.
//  - Counters saturate at all-ones; no wrap.
//  - Reset mid-stall or mid-flush: all in-flight state discarded, behaves as cold reset.
// STRUCTURE
//  - Shared header.vh gains BS_NEXT=2'b00, BS_BRZ=2'b01, BS_JMR=2'b10, BS_JMP=2'b11 and
//    PCSEL_* equal to BS encodings; opcodes stay there. No new opcode constants here.
//  - One sub-module: risc_hazard_cmp (src, used, dst, dst_rw -> match, R0 masked), instantiated
//    2x (A,B) per checked stage.
//  - Shadow regs, priority mux and counters live in this module.
// TESTING
//  - Reset: hold rst_n=0 3 cycles -> pc_en=0, ex_bubble=1, ir_flush=1, counters 0; release -> pc_en=1.
//  - RAW: ADD R3<-R1,R2 then SUB R4<-R3,R5 -> 1 cycle ex_bubble=1, pc_en=0; stall_cnt=1. With
//    RF_WRITE_THROUGH=0 -> 2 cycles, stall_cnt=2.
//  - No false hazard: ADI R3<-R0,#5 then ADI R6<-R3? no: ADI R6<-R7,#1 (mb=1, ma=0, aa=7) after write
//    R3 -> no stall; dest R0 writes never stall readers of R0.
//  - BZ in EX with zero_ex=1, PS=0 -> pc_sel=01, ir_flush=1, ex_bubble=1, flush_cnt=1; same with
//    zero_ex=0 -> pc_sel=00, no flush.
//  - Priority: BNZ taken (zero_ex=0, PS=1) with RAW hazard in DOF -> flush only, stall_cnt unchanged;
//    assert mem_wait same cycle -> all enables 0, shadows/counters unchanged next edge.
//  - Saturation: CNT_W=4, force 20 hazards -> stall_cnt=4'hF, holds.

Source files
------------

// File: rtl/risc_pipeline_ctrl_pkg.sv
// Shared encodings and shadow-register types for the 4-stage RISC pipeline sequencer.
// Branch-select codes double as PC-mux selects.
package risc_pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        BS_NEXT = 2'b00,
        BS_BRZ  = 2'b01,
        BS_JMR  = 2'b10,
        BS_JMP  = 2'b11
    } bs_t;

    localparam logic [1:0] PCSEL_NEXT = 2'b00;
    localparam logic [1:0] PCSEL_BRZ  = 2'b01;
    localparam logic [1:0] PCSEL_JMR  = 2'b10;
    localparam logic [1:0] PCSEL_JMP  = 2'b11;

    typedef enum logic [1:0] {
        MODE_NORMAL,
        MODE_HAZARD,
        MODE_TAKEN,
        MODE_FREEZE
    } pipe_mode_t;

    typedef struct packed {
        logic       rw;
        logic [4:0] da;
        logic [1:0] bs;
        logic       ps;
    } ex_shadow_t;

    typedef struct packed {
        logic       rw;
        logic [4:0] da;
    } wb_shadow_t;

    // BZ (PS=0) / BNZ (PS=1) depend on the flag; JMR and JMP/JML always redirect.
    function automatic logic is_taken(input logic [1:0] bs, input logic ps, input logic zero);
        return ((bs == BS_BRZ) && (zero ^ ps)) || (bs == BS_JMR) || (bs == BS_JMP);
    endfunction

endpackage

// File: rtl/risc_pipeline_ctrl_hazard_cmp.sv
// Single source-vs-destination RAW comparator; R0 is hardwired so it never matches.
module risc_hazard_cmp (
    input  logic [4:0] src,
    input  logic       used,
    input  logic [4:0] dst,
    input  logic       dst_rw,
    output logic       match
);

    assign match = used && dst_rw && (dst != 5'd0) && (src == dst);

endmodule

// File: rtl/risc_pipeline_ctrl.sv
// Pipeline sequencer for the IF/DOF/EX/WB RISC core: shadows decoder fields into EX/WB,
// resolves RAW hazards by stalling and taken branches by flushing, and counts both.
module risc_pipeline_ctrl
    import risc_pipeline_ctrl_pkg::*;
#(
    parameter int RF_WRITE_THROUGH = 1,
    parameter int CNT_W            = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_wait,
    input  logic             rw_dof,
    input  logic [4:0]       da_dof,
    input  logic [4:0]       aa_dof,
    input  logic [4:0]       ba_dof,
    input  logic             ma_dof,
    input  logic             mb_dof,
    input  logic [1:0]       bs_dof,
    input  logic             ps_dof,
    input  logic             zero_ex,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic             ir_en,
    output logic             ir_flush,
    output logic             ex_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ex_shadow_t ex_q;
    wb_shadow_t wb_q;
    pipe_mode_t mode;

    logic a_used, b_used;
    logic ex_a_hit, ex_b_hit, wb_a_hit, wb_b_hit;
    logic hazard, taken;

    assign a_used = !ma_dof;
    assign b_used = !mb_dof;

    risc_hazard_cmp u_cmp_ex_a (.src(aa_dof), .used(a_used), .dst(ex_q.da), .dst_rw(ex_q.rw), .match(ex_a_hit));
    risc_hazard_cmp u_cmp_ex_b (.src(ba_dof), .used(b_used), .dst(ex_q.da), .dst_rw(ex_q.rw), .match(ex_b_hit));
    risc_hazard_cmp u_cmp_wb_a (.src(aa_dof), .used(a_used), .dst(wb_q.da), .dst_rw(wb_q.rw), .match(wb_a_hit));
    risc_hazard_cmp u_cmp_wb_b (.src(ba_dof), .used(b_used), .dst(wb_q.da), .dst_rw(wb_q.rw), .match(wb_b_hit));

    // With a write-through register file the WB write is already visible to DOF reads.
    assign hazard = ex_a_hit || ex_b_hit ||
                    ((RF_WRITE_THROUGH == 0) && (wb_a_hit || wb_b_hit));
    assign taken  = is_taken(ex_q.bs, ex_q.ps, zero_ex);

    always_comb begin
        if (mem_wait)    mode = MODE_FREEZE;
        else if (taken)  mode = MODE_TAKEN;
        else if (hazard) mode = MODE_HAZARD;
        else             mode = MODE_NORMAL;
    end

    // NOTE: every output gets a default before the case, so no path leaves a latch behind.
    always_comb begin
        pc_en     = 1'b0;
        pc_sel    = PCSEL_NEXT;
        ir_en     = 1'b0;
        ir_flush  = 1'b0;
        ex_bubble = 1'b0;
        if (!rst_n) begin
            // Held in reset: keep NOPs flowing into IR and EX so release starts clean.
            ir_flush  = 1'b1;
            ex_bubble = 1'b1;
        end else begin
            unique case (mode)
                MODE_TAKEN: begin
                    pc_en     = 1'b1;
                    pc_sel    = ex_q.bs;
                    ir_en     = 1'b1;
                    ir_flush  = 1'b1;
                    ex_bubble = 1'b1;
                end
                MODE_HAZARD: ex_bubble = 1'b1;
                MODE_NORMAL: begin
                    pc_en = 1'b1;
                    ir_en = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so wb_q samples the old ex_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= '0;
            wb_q      <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!mem_wait) begin
            wb_q.rw <= ex_q.rw;
            wb_q.da <= ex_q.da;
            if (ex_bubble) begin
                ex_q <= '0;
            end else begin
                ex_q.rw <= rw_dof;
                ex_q.da <= da_dof;
                ex_q.bs <= bs_dof;
                ex_q.ps <= ps_dof;
            end
            if (mode == MODE_HAZARD && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_ONE;
            if (mode == MODE_TAKEN && flush_cnt != CNT_MAX)  flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_risc_pipeline_ctrl.sv
// Directed bench for risc_pipeline_ctrl: table of per-cycle vectors on the default build,
// plus hand sequences for no-write-through stalls, branch priority, mid-stall reset and saturation.
module tb_risc_pipeline_ctrl;

    typedef struct packed {
        logic       rw;
        logic [4:0] da;
        logic [4:0] aa;
        logic [4:0] ba;
        logic       ma;
        logic       mb;
        logic [1:0] bs;
        logic       ps;
    } instr_t;

    typedef struct {
        instr_t     ins;
        logic       zero;
        logic       mw;
        logic [5:0] ctl;
        int         stall;
        int         flush;
    } vec_t;

    // ctl = {pc_en, pc_sel[1:0], ir_en, ir_flush, ex_bubble}
    localparam logic [5:0] C_NRM = 6'b1_00_1_0_0;
    localparam logic [5:0] C_HAZ = 6'b0_00_0_0_1;
    localparam logic [5:0] C_FRZ = 6'b0_00_0_0_0;
    localparam logic [5:0] C_T01 = 6'b1_01_1_1_1;
    localparam logic [5:0] C_T10 = 6'b1_10_1_1_1;
    localparam logic [5:0] C_T11 = 6'b1_11_1_1_1;
    localparam logic [5:0] C_RST = 6'b0_00_0_1_1;

    logic clk = 1'b0;
    logic rst_n, mem_wait, rw_dof, ma_dof, mb_dof, ps_dof, zero_ex;
    logic [4:0] da_dof, aa_dof, ba_dof;
    logic [1:0] bs_dof;

    logic pc_en, ir_en, ir_flush, ex_bubble;
    logic [1:0] pc_sel;
    logic [15:0] stall_cnt, flush_cnt;

    logic n_pc_en, n_ir_en, n_ir_flush, n_ex_bubble;
    logic [1:0] n_pc_sel;
    logic [15:0] n_stall_cnt, n_flush_cnt;

    logic s_pc_en, s_ir_en, s_ir_flush, s_ex_bubble;
    logic [1:0] s_pc_sel;
    logic [3:0] s_stall_cnt, s_flush_cnt;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    risc_pipeline_ctrl dut (
        .clk(clk), .rst_n(rst_n), .mem_wait(mem_wait), .rw_dof(rw_dof), .da_dof(da_dof),
        .aa_dof(aa_dof), .ba_dof(ba_dof), .ma_dof(ma_dof), .mb_dof(mb_dof), .bs_dof(bs_dof),
        .ps_dof(ps_dof), .zero_ex(zero_ex), .pc_en(pc_en), .pc_sel(pc_sel), .ir_en(ir_en),
        .ir_flush(ir_flush), .ex_bubble(ex_bubble), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    risc_pipeline_ctrl #(.RF_WRITE_THROUGH(0)) dut_nwt (
        .clk(clk), .rst_n(rst_n), .mem_wait(mem_wait), .rw_dof(rw_dof), .da_dof(da_dof),
        .aa_dof(aa_dof), .ba_dof(ba_dof), .ma_dof(ma_dof), .mb_dof(mb_dof), .bs_dof(bs_dof),
        .ps_dof(ps_dof), .zero_ex(zero_ex), .pc_en(n_pc_en), .pc_sel(n_pc_sel), .ir_en(n_ir_en),
        .ir_flush(n_ir_flush), .ex_bubble(n_ex_bubble), .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt)
    );

    risc_pipeline_ctrl #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .mem_wait(mem_wait), .rw_dof(rw_dof), .da_dof(da_dof),
        .aa_dof(aa_dof), .ba_dof(ba_dof), .ma_dof(ma_dof), .mb_dof(mb_dof), .bs_dof(bs_dof),
        .ps_dof(ps_dof), .zero_ex(zero_ex), .pc_en(s_pc_en), .pc_sel(s_pc_sel), .ir_en(s_ir_en),
        .ir_flush(s_ir_flush), .ex_bubble(s_ex_bubble), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    wire [5:0] ctl   = {pc_en, pc_sel, ir_en, ir_flush, ex_bubble};
    wire [5:0] n_ctl = {n_pc_en, n_pc_sel, n_ir_en, n_ir_flush, n_ex_bubble};
    wire [5:0] s_ctl = {s_pc_en, s_pc_sel, s_ir_en, s_ir_flush, s_ex_bubble};

    function automatic instr_t ins(input logic rw, input logic [4:0] da, input logic [4:0] aa,
                                   input logic [4:0] ba, input logic ma, input logic mb,
                                   input logic [1:0] bs, input logic ps);
        return {rw, da, aa, ba, ma, mb, bs, ps};
    endfunction

    function automatic vec_t mkv(input instr_t i, input logic z, input logic mw,
                                 input logic [5:0] c, input int st, input int fl);
        vec_t v;
        v.ins = i; v.zero = z; v.mw = mw; v.ctl = c; v.stall = st; v.flush = fl;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic apply(input instr_t i, input logic z, input logic mw);
        rw_dof = i.rw; da_dof = i.da; aa_dof = i.aa; ba_dof = i.ba;
        ma_dof = i.ma; mb_dof = i.mb; bs_dof = i.bs; ps_dof = i.ps;
        zero_ex = z; mem_wait = mw;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    instr_t nop, add_r3, sub_r4_r3, adi_r6, add_r0, add_r5_r0, bz, add_r8;
    instr_t jml_r9, add_r10_r9, jmr, add_r11, sub_r12_r11, bnz;
    vec_t vecs[25];

    initial begin
        nop         = ins(0, 0, 0, 0, 0, 0, 2'b00, 0);
        add_r3      = ins(1, 3, 1, 2, 0, 0, 2'b00, 0);
        sub_r4_r3   = ins(1, 4, 3, 5, 0, 0, 2'b00, 0);
        adi_r6      = ins(1, 6, 7, 4, 0, 1, 2'b00, 0);
        add_r0      = ins(1, 0, 1, 2, 0, 0, 2'b00, 0);
        add_r5_r0   = ins(1, 5, 0, 0, 0, 0, 2'b00, 0);
        bz          = ins(0, 0, 1, 0, 0, 1, 2'b01, 0);
        add_r8      = ins(1, 8, 1, 2, 0, 0, 2'b00, 0);
        jml_r9      = ins(1, 9, 1, 0, 0, 1, 2'b11, 0);
        add_r10_r9  = ins(1, 10, 9, 1, 0, 0, 2'b00, 0);
        jmr         = ins(0, 0, 2, 0, 0, 1, 2'b10, 0);
        add_r11     = ins(1, 11, 1, 2, 0, 0, 2'b00, 0);
        sub_r12_r11 = ins(1, 12, 11, 1, 0, 0, 2'b00, 0);
        bnz         = ins(0, 0, 1, 0, 0, 1, 2'b01, 1);

        vecs[0]  = mkv(nop,         0, 0, C_NRM, 0, 0);
        vecs[1]  = mkv(add_r3,      0, 0, C_NRM, 0, 0);
        vecs[2]  = mkv(sub_r4_r3,   0, 0, C_HAZ, 0, 0);
        vecs[3]  = mkv(sub_r4_r3,   0, 0, C_NRM, 1, 0);
        vecs[4]  = mkv(adi_r6,      0, 0, C_NRM, 1, 0);
        vecs[5]  = mkv(add_r0,      0, 0, C_NRM, 1, 0);
        vecs[6]  = mkv(add_r5_r0,   0, 0, C_NRM, 1, 0);
        vecs[7]  = mkv(bz,          0, 0, C_NRM, 1, 0);
        vecs[8]  = mkv(add_r8,      1, 0, C_T01, 1, 0);
        vecs[9]  = mkv(nop,         1, 0, C_NRM, 1, 1);
        vecs[10] = mkv(bz,          0, 0, C_NRM, 1, 1);
        vecs[11] = mkv(nop,         0, 0, C_NRM, 1, 1);
        vecs[12] = mkv(jml_r9,      0, 0, C_NRM, 1, 1);
        vecs[13] = mkv(add_r10_r9,  0, 0, C_T11, 1, 1);
        vecs[14] = mkv(add_r10_r9,  0, 0, C_NRM, 1, 2);
        vecs[15] = mkv(jmr,         0, 0, C_NRM, 1, 2);
        vecs[16] = mkv(nop,         0, 0, C_T10, 1, 2);
        vecs[17] = mkv(add_r11,     0, 0, C_NRM, 1, 3);
        vecs[18] = mkv(sub_r12_r11, 0, 1, C_FRZ, 1, 3);
        vecs[19] = mkv(sub_r12_r11, 0, 0, C_HAZ, 1, 3);
        vecs[20] = mkv(sub_r12_r11, 0, 0, C_NRM, 2, 3);
        vecs[21] = mkv(bnz,         0, 0, C_NRM, 2, 3);
        vecs[22] = mkv(nop,         0, 1, C_FRZ, 2, 3);
        vecs[23] = mkv(nop,         0, 0, C_T01, 2, 3);
        vecs[24] = mkv(nop,         0, 0, C_NRM, 2, 4);

        // Cold reset held for three cycles.
        rst_n = 1'b0;
        apply(nop, 0, 0);
        repeat (3) tick();
        check("reset ctl", 32'(ctl), 32'(C_RST));
        check("reset stall_cnt", 32'(stall_cnt), 0);
        check("reset flush_cnt", 32'(flush_cnt), 0);
        check("reset nwt ctl", 32'(n_ctl), 32'(C_RST));
        rst_n = 1'b1;
        #1;
        check("release ctl", 32'(ctl), 32'(C_NRM));

        for (int i = 0; i < 25; i++) begin
            apply(vecs[i].ins, vecs[i].zero, vecs[i].mw);
            check($sformatf("v%0d ctl", i), 32'(ctl), 32'(vecs[i].ctl));
            check($sformatf("v%0d stall_cnt", i), 32'(stall_cnt), vecs[i].stall);
            check($sformatf("v%0d flush_cnt", i), 32'(flush_cnt), vecs[i].flush);
            tick();
        end

        // No write-through: RAW stalls for two cycles.
        apply(nop, 0, 0);
        do_reset();
        apply(add_r3, 0, 0);
        check("nwt add ctl", 32'(n_ctl), 32'(C_NRM));
        tick();
        apply(sub_r4_r3, 0, 0);
        check("nwt stall1 ctl", 32'(n_ctl), 32'(C_HAZ));
        tick();
        check("nwt stall2 ctl", 32'(n_ctl), 32'(C_HAZ));
        tick();
        check("nwt resume ctl", 32'(n_ctl), 32'(C_NRM));
        check("nwt stall_cnt", 32'(n_stall_cnt), 2);
        tick();

        // Taken BNZ in EX beats a WB-stage hazard in DOF.
        apply(nop, 0, 0);
        do_reset();
        apply(add_r3, 0, 0);
        tick();
        apply(bnz, 0, 0);
        check("nwt bnz dof ctl", 32'(n_ctl), 32'(C_NRM));
        tick();
        apply(sub_r4_r3, 0, 0);
        check("nwt bnz+haz ctl", 32'(n_ctl), 32'(C_T01));
        tick();
        check("nwt bnz stall_cnt", 32'(n_stall_cnt), 0);
        check("nwt bnz flush_cnt", 32'(n_flush_cnt), 1);

        // Reset in the middle of a stall discards the in-flight producer.
        apply(nop, 0, 0);
        do_reset();
        apply(add_r3, 0, 0);
        tick();
        apply(sub_r4_r3, 0, 0);
        check("midrst stall ctl", 32'(ctl), 32'(C_HAZ));
        tick();
        apply(add_r3, 0, 0);
        tick();
        apply(sub_r4_r3, 0, 0);
        check("midrst stall2 ctl", 32'(ctl), 32'(C_HAZ));
        check("midrst pre cnt", 32'(stall_cnt), 1);
        rst_n = 1'b0;
        #1;
        check("midrst reset ctl", 32'(ctl), 32'(C_RST));
        check("midrst reset cnt", 32'(stall_cnt), 0);
        tick();
        rst_n = 1'b1;
        #1;
        check("midrst release ctl", 32'(ctl), 32'(C_NRM));

        // Twenty hazards: 4-bit counter pins at F, 16-bit counter reaches 20.
        apply(nop, 0, 0);
        do_reset();
        for (int i = 0; i < 20; i++) begin
            apply(add_r3, 0, 0);
            tick();
            apply(sub_r4_r3, 0, 0);
            tick();
            tick();
        end
        check("sat stall_cnt", 32'(s_stall_cnt), 32'hF);
        check("wide stall_cnt", 32'(stall_cnt), 20);
        apply(add_r3, 0, 0);
        tick();
        apply(sub_r4_r3, 0, 0);
        check("sat extra haz ctl", 32'(s_ctl), 32'(C_HAZ));
        tick();
        check("sat hold stall_cnt", 32'(s_stall_cnt), 32'hF);
        check("wide stall_cnt 21", 32'(stall_cnt), 21);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
